// File: rtl/hex_entry_interface.sv
// Hex keypad-style entry: three debounced push-buttons shift nibbles from iSW into a
// working register, clear it, or commit it to oValue with a one-cycle oValid strobe.
module hex_entry_interface #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned WIDTH           = 64
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [3:0]       iSW,
    input  logic             iKEY_Enter,
    input  logic             iKEY_Clear,
    input  logic             iKEY_Commit,
    output logic [WIDTH-1:0] oEntry,
    output logic [4:0]       oCount,
    output logic             oFull,
    output logic [WIDTH-1:0] oValue,
    output logic             oValid
);

    localparam int unsigned NIBBLES    = WIDTH / 4;
    localparam int unsigned KEYS       = 3;
    localparam int unsigned KEY_ENTER  = 0;
    localparam int unsigned KEY_CLEAR  = 1;
    localparam int unsigned KEY_COMMIT = 2;
    localparam int unsigned CNT_W      = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       COUNT_MAX = 5'(NIBBLES);

    logic [KEYS-1:0]  keyRaw;
    logic [KEYS-1:0]  keySync1;
    logic [KEYS-1:0]  keySync2;
    logic [KEYS-1:0]  keyLevel;
    logic [KEYS-1:0]  keyLevelPrev;
    logic [KEYS-1:0]  keyPress;
    logic [CNT_W-1:0] debCnt [KEYS];

    assign keyRaw = {iKEY_Commit, iKEY_Clear, iKEY_Enter};

    // Synchronise and debounce each key; the level only follows sync2 after a full stable run.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            keySync1     <= '1;
            keySync2     <= '1;
            keyLevel     <= '1;
            keyLevelPrev <= '1;
            for (int k = 0; k < int'(KEYS); k++) begin
                debCnt[k] <= '0;
            end
        end else begin
            keySync1     <= keyRaw;
            keySync2     <= keySync1;
            keyLevelPrev <= keyLevel;
            for (int k = 0; k < int'(KEYS); k++) begin
                if (keySync2[k] == keyLevel[k]) begin
                    debCnt[k] <= '0;
                end else if (debCnt[k] == CNT_LAST) begin
                    keyLevel[k] <= keySync2[k];
                    debCnt[k]   <= '0;
                end else begin
                    debCnt[k] <= debCnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Press event is a falling edge of the debounced level, built purely from registers.
    assign keyPress = keyLevelPrev & ~keyLevel;

    // One action per cycle: Clear beats Commit beats Enter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oEntry <= '0;
            oCount <= '0;
            oValue <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (keyPress[KEY_CLEAR]) begin
                oEntry <= '0;
                oCount <= '0;
            end else if (keyPress[KEY_COMMIT]) begin
                oValue <= oEntry;
                oValid <= 1'b1;
                oEntry <= '0;
                oCount <= '0;
            end else if (keyPress[KEY_ENTER] && (oCount < COUNT_MAX)) begin
                oEntry <= WIDTH'({oEntry, iSW});
                oCount <= oCount + 5'd1;
            end
        end
    end

    assign oFull = (oCount == COUNT_MAX);

endmodule

// File: tb/tb_hex_entry_interface.sv
// Randomised scoreboard bench for hex_entry_interface: a key-level model predicts each
// visible update and its edge; a negedge monitor pops and compares every observed update.
module tb_hex_entry_interface;

    localparam int unsigned DEB = 4;
    localparam int unsigned W   = 64;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic [3:0]    iSW;
    logic          iKEY_Enter;
    logic          iKEY_Clear;
    logic          iKEY_Commit;
    logic [W-1:0]  oEntry;
    logic [4:0]    oCount;
    logic          oFull;
    logic [W-1:0]  oValue;
    logic          oValid;

    hex_entry_interface #(.DEBOUNCE_CYCLES(DEB), .WIDTH(W)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iSW         (iSW),
        .iKEY_Enter  (iKEY_Enter),
        .iKEY_Clear  (iKEY_Clear),
        .iKEY_Commit (iKEY_Commit),
        .oEntry      (oEntry),
        .oCount      (oCount),
        .oFull       (oFull),
        .oValue      (oValue),
        .oValid      (oValid)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int          edgeNo;
        logic [63:0] entry;
        logic [4:0]  count;
        logic        full;
        logic [63:0] value;
        logic        valid;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    int          nCmp = 0;
    int          nErr = 0;
    int          cyc = 0;
    logic        rstAtEdge = 1'b1;
    logic [63:0] mEntry;
    logic [63:0] mValue;
    int          mCount;
    logic [63:0] prevE;
    logic [63:0] prevV;
    logic [4:0]  prevC;

    always @(posedge iCLK) begin
        cyc       <= cyc + 1;
        rstAtEdge <= iRST;
    end

    // Monitor: any visible change (or a valid strobe) must match the next predicted update.
    always @(negedge iCLK) begin
        if (!rstAtEdge && (oValid || oEntry !== prevE || oCount !== prevC || oValue !== prevV)) begin
            nCmp++;
            if (expQ.size() == 0) begin
                nErr++;
                $display("FAIL unexpected_update: edge %0d entry=%h count=%0d valid=%b value=%h, required no change",
                         cyc, oEntry, oCount, oValid, oValue);
            end else begin
                monExp = expQ.pop_front();
                if (cyc != monExp.edgeNo || oEntry !== monExp.entry || oCount !== monExp.count ||
                    oFull !== monExp.full || oValue !== monExp.value || oValid !== monExp.valid) begin
                    nErr++;
                    $display("FAIL update_check: got edge %0d entry=%h count=%0d full=%b value=%h valid=%b; required edge %0d entry=%h count=%0d full=%b value=%h valid=%b",
                             cyc, oEntry, oCount, oFull, oValue, oValid,
                             monExp.edgeNo, monExp.entry, monExp.count, monExp.full, monExp.value, monExp.valid);
                end
            end
        end
        prevE = oEntry;
        prevC = oCount;
        prevV = oValue;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nCmp++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_entry"}, oEntry, 64'h0);
        chk({tag, "_count"}, 64'(oCount), 64'h0);
        chk({tag, "_full"}, 64'(oFull), 64'h0);
        chk({tag, "_value"}, oValue, 64'h0);
        chk({tag, "_valid"}, 64'(oValid), 64'h0);
    endtask

    // Press keys cleanly for 'hold' cycles; the model predicts the outcome from the key rules.
    task automatic issue(input bit en, input bit cl, input bit cm, input logic [3:0] nib, input int hold);
        exp_t e;
        bit   push;
        push = 1'b0;
        iSW  = nib;
        e.edgeNo = cyc + int'(DEB) + 3;
        if (cl) begin
            push   = (mCount != 0);
            mEntry = 64'h0;
            mCount = 0;
        end else if (cm) begin
            mValue = mEntry;
            mEntry = 64'h0;
            mCount = 0;
            push   = 1'b1;
        end else if (en && mCount < 16) begin
            mEntry = mEntry * 16 + 64'(nib);
            mCount = mCount + 1;
            push   = 1'b1;
        end
        if (push) begin
            e.entry = mEntry;
            e.count = 5'(mCount);
            e.full  = (mCount == 16);
            e.value = mValue;
            e.valid = cm && !cl;
            expQ.push_back(e);
        end
        iKEY_Enter  = !en;
        iKEY_Clear  = !cl;
        iKEY_Commit = !cm;
        step(hold);
        iKEY_Enter  = 1'b1;
        iKEY_Clear  = 1'b1;
        iKEY_Commit = 1'b1;
        step(int'(DEB) + 6);
    endtask

    task automatic glitch(input int key, input int len);
        if (key == 0) iKEY_Enter = 1'b0;
        else if (key == 1) iKEY_Clear = 1'b0;
        else iKEY_Commit = 1'b0;
        step(len);
        iKEY_Enter  = 1'b1;
        iKEY_Clear  = 1'b1;
        iKEY_Commit = 1'b1;
        step(int'(DEB) + 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r;
        int   hold;
        int   rstEdge;
        exp_t e;
        bit   ben, bcl, bcm;

        iRST = 1'b1;
        iSW = 4'h0;
        iKEY_Enter = 1'b1;
        iKEY_Clear = 1'b1;
        iKEY_Commit = 1'b1;
        mEntry = 64'h0;
        mValue = 64'h0;
        mCount = 0;
        step(3);
        chkAllZero("reset");
        iRST = 1'b0;
        step(2);

        // Three clean entries
        issue(1, 0, 0, 4'h1, DEB + 4);
        issue(1, 0, 0, 4'h2, DEB + 4);
        issue(1, 0, 0, 4'h3, DEB + 4);
        chk("t1_entry", oEntry, 64'h123);
        chk("t1_count", 64'(oCount), 64'd3);
        chk("t1_full", 64'(oFull), 64'd0);

        // Commit paths
        issue(0, 0, 1, 4'h0, DEB + 4);
        chk("t4a_value", oValue, 64'h123);
        issue(1, 0, 0, 4'hA, DEB + 4);
        issue(1, 0, 0, 4'hB, DEB + 4);
        issue(1, 0, 0, 4'hC, DEB + 4);
        issue(1, 0, 0, 4'hD, DEB + 4);
        issue(0, 0, 1, 4'h0, DEB + 4);
        chk("t4_value", oValue, 64'hABCD);
        chk("t4_entry", oEntry, 64'h0);
        chk("t4_count", 64'(oCount), 64'd0);

        // Fill to capacity and overflow
        for (int i = 0; i < 17; i++) issue(1, 0, 0, 4'hF, DEB + 4);
        chk("t2_entry", oEntry, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_count", 64'(oCount), 64'd16);
        chk("t2_full", 64'(oFull), 64'd1);

        // Glitch rejection then a long hold
        issue(0, 1, 0, 4'h0, DEB + 4);
        glitch(0, 3);
        chk("t3_glitch_count", 64'(oCount), 64'd0);
        issue(1, 0, 0, 4'h9, 30);
        chk("t3_hold_count", 64'(oCount), 64'd1);

        // Simultaneous Clear and Commit
        issue(1, 0, 0, 4'h5, DEB + 4);
        issue(1'($urandom_range(0, 1)), 1, 1, 4'h6, DEB + 4);
        chk("t5_entry", oEntry, 64'h0);
        chk("t5_value", oValue, 64'hABCD);

        // Reset while Enter is held
        for (int i = 0; i < 5; i++) issue(1, 0, 0, 4'(i + 1), DEB + 4);
        iSW = 4'h7;
        iKEY_Enter = 1'b0;
        step(2);
        iRST = 1'b1;
        step(1);
        chkAllZero("t6_reset");
        iRST = 1'b0;
        rstEdge = cyc;
        mEntry = 64'h7;
        mCount = 1;
        mValue = 64'h0;
        e.edgeNo = rstEdge + int'(DEB) + 3;
        e.entry = mEntry;
        e.count = 5'd1;
        e.full = 1'b0;
        e.value = 64'h0;
        e.valid = 1'b0;
        expQ.push_back(e);
        step(20);
        iKEY_Enter = 1'b1;
        step(int'(DEB) + 6);
        chk("t6_count", 64'(oCount), 64'd1);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            r    = int'($urandom_range(0, 9));
            hold = int'($urandom_range(DEB + 3, DEB + 12));
            if (r <= 5) begin
                issue(1, 0, 0, 4'($urandom), hold);
            end else if (r == 6) begin
                issue(0, 1, 0, 4'($urandom), hold);
            end else if (r == 7) begin
                issue(0, 0, 1, 4'($urandom), hold);
            end else if (r == 8) begin
                ben = 1'($urandom);
                bcl = 1'($urandom);
                bcm = 1'($urandom);
                if (!(ben || bcl || bcm)) ben = 1'b1;
                issue(ben, bcl, bcm, 4'($urandom), hold);
            end else begin
                glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, DEB - 1)));
            end
        end

        step(10);
        nCmp++;
        if (expQ.size() != 0) begin
            nErr++;
            $display("FAIL missing_updates: got %0d predicted updates never observed, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
